piso_serializer_tx: RTL and testbench
=====================================

// Module: piso_serializer_tx
// PURPOSE
//   Parallel-in/serial-out transmitter: the serial send side paired with the team's parallel registers.
//   Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock.
//   Emits frame_start and frame_done markers with each word. Supports a stall input (hold).
//   Allows back-to-back words with no idle gap.
// PARAMETERS
//   WIDTH      4   word width in bits; legal range WIDTH >= 2
//   LSB_FIRST  1   1: bit 0 is transmitted first; 0: bit WIDTH-1 is transmitted first
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      reset; asynchronous, active-low (0 = reset)
//   load_valid   in   1      parallel_in holds a word to send
//   load_ready   out  1      block can accept a word this cycle
//   parallel_in  in   WIDTH  word to serialize; sampled only on accept
//   hold         in   1      stall; freezes the shift while high
//   serial_out   out  1      current serial bit
//   serial_valid out  1      serial_out carries a valid bit
//   frame_start  out  1      high while the first bit of a word is on serial_out
//   frame_done   out  1      high while the last bit of a word is on serial_out
// BEHAVIOUR
//   - Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit counter=0.
//     Outputs serial_out, serial_valid, frame_start and frame_done are all 0. load_ready is forced to 0.
//   - States:
//     - IDLE: serial_valid=0 and serial_out=0. load_ready=1.
//     - SHIFT: serial_valid=1. Counter cnt runs from 0 to WIDTH-1 (clog2(WIDTH) bits).
//   - accept = load_valid & load_ready, evaluated at the rising clock edge.
//   - load_ready is combinational:
//     - 1 in IDLE.
//     - 1 in SHIFT when cnt==WIDTH-1 and hold==0.
//     - 0 otherwise.
//   - On accept: capture parallel_in, set cnt=0, enter SHIFT.
//     Latency is 1 cycle: the first bit appears on the next cycle with frame_start=1.
//   - In SHIFT with hold=0: advance by one bit and increment cnt.
//     At cnt==WIDTH-1 the next state is SHIFT with the new word if accept, otherwise IDLE.
//   - In SHIFT with hold=1: serial_out, serial_valid, frame_start, frame_done and cnt are all stable.
//     No accept is possible.
//   - hold in IDLE has no effect.
//   - frame_start = SHIFT & cnt==0. frame_done = SHIFT & cnt==WIDTH-1.
//   - Throughput: one word per WIDTH cycles with hold=0 and load_valid held high. There is no gap bit.
//   - Bit order: LSB_FIRST=1 sends parallel_in[0] through parallel_in[WIDTH-1]; LSB_FIRST=0 sends the reverse.
//   - parallel_in changing after accept does not affect the word in flight.
//   - Reset asserted mid-word: the word is dropped. serial_valid falls asynchronously.
//     After release the block is in IDLE.
//   - All outputs are registered except load_ready.
// TESTING
//   - Reset then release, with load_valid=0:
//     -> serial_valid=0, serial_out=0, load_ready=1; load_ready=0 while rst=0.
//   - WIDTH=4, LSB_FIRST=1, accept 4'b1011:
//     -> serial_out 1,1,0,1 on the next 4 cycles; frame_start on bit 1, frame_done on bit 4; then IDLE.
//   - LSB_FIRST=0, accept 4'b1000:
//     -> serial_out 1,0,0,0 in order.
//   - Back-to-back words 4'hA then 4'h5, load_valid held high:
//     -> 8 consecutive valid bits 0,1,0,1,1,0,1,0 with no gap; 2 frame_start and 2 frame_done pulses.
//   - hold=1 for 3 cycles during bit 2 of 4'b0110:
//     -> bit 2 (value 1) is held for 4 cycles total; then the sequence completes; load_ready=0 during the hold.
//   - rst pulsed low during bit 3:
//     -> serial_valid=0 immediately; after release the next accepted word starts with frame_start.

Source files
------------

// File: rtl/piso_serializer_tx.sv
// piso_serializer_tx: parallel-in / serial-out transmitter.
// Takes a word over valid/ready and shifts it out one bit per clock.
//
// Parameters:
//   WIDTH       word width in bits (>= 2)
//   LSB_FIRST   1: bit 0 goes out first, 0: bit WIDTH-1 goes out first
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   load_valid   parallel_in carries a word to send
//   load_ready   a word can be accepted this cycle (combinational)
//   parallel_in  word to serialize, sampled only on accept
//   hold         stall, freezes the shift while high
//   serial_out   current serial bit (registered)
//   serial_valid serial_out carries a valid bit (registered)
//   frame_start  first bit of a word is on serial_out (registered)
//   frame_done   last bit of a word is on serial_out (registered)

module piso_serializer_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             hold,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             sv_q, sv_d;
  logic             fs_q, fs_d;
  logic             fd_q, fd_d;

  logic in_shift;
  logic is_last;
  logic advance;
  logic accept;
  logic drain;
  logic step;

  assign in_shift = (state_q == S_SHIFT);
  assign is_last  = in_shift && (cnt_q == CNT_LAST);
  assign advance  = in_shift && !hold;

  // Gated by rst so the block never looks ready while held in reset.
  assign load_ready = rst &&
                      ((state_q == S_IDLE) || (is_last && !hold));

  assign accept = load_valid && load_ready;

  // The three transitions are mutually exclusive by construction:
  // a last-bit accept is covered by accept, so drain requires no valid.
  assign drain = advance && is_last && !load_valid;
  assign step  = advance && !is_last;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      accept: begin
        state_d = S_SHIFT;
        shreg_d = parallel_in;
        cnt_d   = '0;
      end
      drain: begin
        state_d = S_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
      step: begin
        if (LSB_FIRST) begin
          shreg_d = shreg_q >> 1;
        end else begin
          shreg_d = shreg_q << 1;
        end
        cnt_d = cnt_q + CW'(1);
      end
      default: begin
      end
    endcase
  end

  // Output flops are loaded from next-state so they line up with the
  // bit being presented; a hold leaves next-state equal to current.
  always_comb begin
    sv_d = (state_d == S_SHIFT);
    if (LSB_FIRST) begin
      so_d = sv_d && shreg_d[0];
    end else begin
      so_d = sv_d && shreg_d[WIDTH-1];
    end
    fs_d = sv_d && (cnt_d == '0);
    fd_d = sv_d && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      sv_q    <= sv_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  assign serial_out   = so_q;
  assign serial_valid = sv_q;
  assign frame_start  = fs_q;
  assign frame_done   = fd_q;

endmodule

// File: tb/tb_piso_serializer_tx.sv
// tb_piso_serializer_tx: directed bench for piso_serializer_tx.
// Drives an LSB-first and an MSB-first instance with shared stimulus.

module tb_piso_serializer_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] parallel_in = 4'h0;

  logic rdy_l, so_l, sv_l, fs_l, fd_l;
  logic rdy_m, so_m, sv_m, fs_m, fd_m;

  always #5 clk = ~clk;

  piso_serializer_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (rdy_l),
    .parallel_in  (parallel_in),
    .hold         (hold),
    .serial_out   (so_l),
    .serial_valid (sv_l),
    .frame_start  (fs_l),
    .frame_done   (fd_l)
  );

  piso_serializer_tx #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (rdy_m),
    .parallel_in  (parallel_in),
    .hold         (hold),
    .serial_out   (so_m),
    .serial_valid (sv_m),
    .frame_start  (fs_m),
    .frame_done   (fd_m)
  );

  // e = {rdy, so_lsb, sv, fs, fd, so_msb}
  typedef struct {
    bit       r;
    bit       lv;
    bit [3:0] p;
    bit       h;
    bit [5:0] e;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic add(input bit r, input bit lv, input bit [3:0] p,
                     input bit h, input bit [5:0] e);
    vec_t v;
    v.r = r; v.lv = lv; v.p = p; v.h = h; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    int cyc;
    // reset held, valid ignored
    add(0, 0, 4'h0, 0, 6'b000000);
    add(0, 1, 4'hB, 0, 6'b000000);
    add(1, 0, 4'h0, 0, 6'b100000);
    // 4'b1011
    add(1, 1, 4'hB, 0, 6'b100000);
    add(1, 0, 4'hB, 0, 6'b011101);
    add(1, 0, 4'hB, 0, 6'b011000);
    add(1, 0, 4'hB, 0, 6'b001001);
    add(1, 0, 4'hB, 0, 6'b111011);
    add(1, 0, 4'hB, 0, 6'b100000);
    // 4'b1000, input changes after accept
    add(1, 1, 4'h8, 0, 6'b100000);
    add(1, 0, 4'h7, 0, 6'b001101);
    add(1, 0, 4'h7, 0, 6'b001000);
    add(1, 0, 4'h7, 0, 6'b001000);
    add(1, 0, 4'h7, 0, 6'b111010);
    add(1, 0, 4'h7, 0, 6'b100000);
    // back-to-back A then 5
    add(1, 1, 4'hA, 0, 6'b100000);
    add(1, 1, 4'h5, 0, 6'b001101);
    add(1, 1, 4'h5, 0, 6'b011000);
    add(1, 1, 4'h5, 0, 6'b001001);
    add(1, 1, 4'h5, 0, 6'b111010);
    add(1, 0, 4'h5, 0, 6'b011100);
    add(1, 0, 4'h5, 0, 6'b001001);
    add(1, 0, 4'h5, 0, 6'b011000);
    add(1, 0, 4'h5, 0, 6'b101011);
    add(1, 0, 4'h5, 0, 6'b100000);
    // 4'b0110 with hold on bit 2, then hold on last bit
    add(1, 1, 4'h6, 0, 6'b100000);
    add(1, 0, 4'h6, 0, 6'b001100);
    add(1, 0, 4'h6, 1, 6'b011001);
    add(1, 0, 4'h6, 1, 6'b011001);
    add(1, 0, 4'h6, 1, 6'b011001);
    add(1, 0, 4'h6, 0, 6'b011001);
    add(1, 0, 4'h6, 0, 6'b011001);
    add(1, 1, 4'hF, 1, 6'b001010);
    add(1, 0, 4'hF, 0, 6'b101010);
    add(1, 0, 4'hF, 0, 6'b100000);
    // hold in IDLE has no effect, 4'b1001
    add(1, 1, 4'h9, 1, 6'b100000);
    add(1, 0, 4'h9, 0, 6'b011101);
    add(1, 0, 4'h9, 0, 6'b001000);
    add(1, 0, 4'h9, 0, 6'b001000);
    add(1, 0, 4'h9, 0, 6'b111011);
    add(1, 0, 4'h9, 0, 6'b100000);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r;
      load_valid = tbl[i].lv;
      parallel_in = tbl[i].p;
      hold = tbl[i].h;
      #1;
      chk($sformatf("v%0d.rdy", i), rdy_l, tbl[i].e[5]);
      chk($sformatf("v%0d.so", i), so_l, tbl[i].e[4]);
      chk($sformatf("v%0d.sv", i), sv_l, tbl[i].e[3]);
      chk($sformatf("v%0d.fs", i), fs_l, tbl[i].e[2]);
      chk($sformatf("v%0d.fd", i), fd_l, tbl[i].e[1]);
      chk($sformatf("v%0d.so_msb", i), so_m, tbl[i].e[0]);
      chk($sformatf("v%0d.sv_msb", i), sv_m, tbl[i].e[3]);
    end

    // reset pulsed mid-word, 4'b1101
    @(negedge clk);
    rst = 1'b1; load_valid = 1'b1; parallel_in = 4'hD; hold = 1'b0;
    #1 chk("rw.rdy", rdy_l, 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    #1 chk("rw.fs", fs_l, 1'b1);
    chk("rw.b0", so_l, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 chk("rw.b2_sv", sv_l, 1'b1);
    chk("rw.b2_so", so_l, 1'b1);
    chk("rw.b2_so_msb", so_m, 1'b0);
    #2 rst = 1'b0;
    #1 chk("rw.async_sv", sv_l, 1'b0);
    chk("rw.async_sv_msb", sv_m, 1'b0);
    chk("rw.async_so", so_l, 1'b0);
    chk("rw.async_fs", fs_l, 1'b0);
    chk("rw.async_rdy", rdy_l, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 chk("rw.in_rst_sv", sv_l, 1'b0);
    rst = 1'b1;
    #1 chk("rw.rel_rdy", rdy_l, 1'b1);
    chk("rw.rel_sv", sv_l, 1'b0);
    load_valid = 1'b1; parallel_in = 4'h3;
    @(posedge clk);
    #1 load_valid = 1'b0;
    chk("rw.new_fs", fs_l, 1'b1);
    chk("rw.new_sv", sv_l, 1'b1);
    chk("rw.new_b0", so_l, 1'b1);
    chk("rw.new_b0_msb", so_m, 1'b0);
    cyc = 0;
    while (fd_l !== 1'b1 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("rw.done_lat", cyc, 4);
    chk("rw.last_bit", so_l, 1'b0);
    @(negedge clk);
    #1 chk("rw.idle_sv", sv_l, 1'b0);
    chk("rw.idle_rdy", rdy_l, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
